// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_HOLD   = 2'd3
    } led_mode_e;

    localparam int unsigned PWM_W = 8;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider: one-cycle tick every DIV enabled cycles, with a synchronous clear.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV = 2500000
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned      CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    // A clear in the same cycle as the terminal count swallows the tick.
    assign o_tick    = i_en && w_at_last && !i_clr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Parametrised LED pattern sequencer (rotate / bounce / bar-fill / hold).
// Optional macro LED_SEQ_PWM_EN adds a bright[7:0] input and PWM dimming of the LED drive.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned N_LEDS = 4,
    parameter int unsigned DIV    = 2500000
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              dir,
`ifdef LED_SEQ_PWM_EN
    input  logic [PWM_W-1:0]  bright,
`endif
    output logic [N_LEDS-1:0] led,
    output logic              step,
    output logic              wrap
);

    localparam logic [N_LEDS-1:0] ONE  = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] MSB1 = ONE << (N_LEDS - 1);

    led_mode_e         w_mode;
    led_mode_e         r_mode_q;
    logic              r_dir_q;
    logic              w_change;
    logic              w_tick;
    logic [N_LEDS-1:0] r_pat;
    logic              r_step;
    logic              r_wrap;
    logic              r_rev;

    logic [N_LEDS-1:0] w_start, w_far, w_fwd, w_back, w_grow, w_adv, w_next;
    logic              w_onehot, w_bar, w_legal, w_wrap_n;

    assign w_mode   = led_mode_e'(mode);
    assign w_change = (w_mode != r_mode_q) || (dir != r_dir_q);

    led_tick_gen #(.DIV(DIV)) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_clr  (w_change),
        .o_tick (w_tick)
    );

    always_comb begin
        w_start  = dir ? MSB1 : ONE;
        w_far    = dir ? ONE : MSB1;
        w_fwd    = dir ? {r_pat[0], r_pat[N_LEDS-1:1]} : {r_pat[N_LEDS-2:0], r_pat[N_LEDS-1]};
        w_back   = dir ? {r_pat[N_LEDS-2:0], r_pat[N_LEDS-1]} : {r_pat[0], r_pat[N_LEDS-1:1]};
        w_grow   = dir ? {1'b1, r_pat[N_LEDS-1:1]} : {r_pat[N_LEDS-2:0], 1'b1};
        w_onehot = (r_pat != '0) && ((r_pat & (r_pat - ONE)) == '0);
        // A bar from the start side: low-aligned ones (dir=0) or high-aligned ones (dir=1).
        w_bar    = dir ? (((~r_pat) & ((~r_pat) + ONE)) == '0)
                       : ((r_pat & (r_pat + ONE)) == '0);
        w_adv    = r_pat;
        w_legal  = 1'b0;
        case (w_mode)
            MODE_ROTATE: begin
                w_legal = w_onehot;
                w_adv   = w_fwd;
            end
            MODE_BOUNCE: begin
                w_legal = w_onehot;
                w_adv   = r_rev ? w_back : w_fwd;
            end
            MODE_FILL: begin
                w_start = '0;
                w_legal = w_bar;
                w_adv   = (r_pat == '1) ? '0 : w_grow;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        w_next   = w_legal ? w_adv : w_start;
        w_wrap_n = w_legal && (w_adv == w_start);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat    <= '0;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
            r_rev    <= 1'b0;
            r_mode_q <= MODE_ROTATE;
            r_dir_q  <= 1'b0;
        end else begin
            r_mode_q <= w_mode;
            r_dir_q  <= dir;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
            if (w_change) begin
                r_pat <= '0;
                r_rev <= 1'b0;
            end else if (w_tick && (w_mode != MODE_HOLD)) begin
                r_pat  <= w_next;
                r_step <= 1'b1;
                r_wrap <= w_wrap_n;
                // Bounce reverses on reaching the far end and resumes on returning to start.
                if (w_next == w_far) begin
                    r_rev <= 1'b1;
                end else if (w_next == w_start) begin
                    r_rev <= 1'b0;
                end
            end
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    assign led = r_pat & {N_LEDS{r_pwm_cnt < bright}};
`else
    assign led = r_pat;
`endif

    assign step = r_step;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: vector tables, corner sequences and a randomized model run.
module tb_led_seq_ctrl;

    localparam int N0 = 4;
    localparam int D0 = 4;
    localparam int N1 = 5;
    localparam int D1 = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic          dir;
    logic [N0-1:0] led0;
    logic [N1-1:0] led1;
    logic          step0, wrap0, step1, wrap1;

    always #5 clk = ~clk;

    led_seq_ctrl #(.N_LEDS(N0), .DIV(D0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
        .led(led0), .step(step0), .wrap(wrap0)
    );

    led_seq_ctrl #(.N_LEDS(N1), .DIV(D1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
        .led(led1), .step(step1), .wrap(wrap1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position index within the mode's cycle, not a bit pattern.
    int       m_cnt  [2];
    int       m_k    [2];
    bit       m_idle [2];
    bit       m_step [2];
    bit       m_wrap [2];
    bit [1:0] m_mq   [2];
    bit       m_dq   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int n;
            int dv;
            int per;
            bit tick;
            n    = (i == 0) ? N0 : N1;
            dv   = (i == 0) ? D0 : D1;
            tick = en && (m_cnt[i] == dv - 1);
            m_step[i] = 1'b0;
            m_wrap[i] = 1'b0;
            if (rst) begin
                m_cnt[i]  = 0;
                m_k[i]    = 0;
                m_idle[i] = 1'b1;
                m_mq[i]   = 2'd0;
                m_dq[i]   = 1'b0;
            end else begin
                if (mode != m_mq[i] || dir != m_dq[i]) begin
                    m_cnt[i]  = 0;
                    m_k[i]    = 0;
                    m_idle[i] = 1'b1;
                end else begin
                    if (en) m_cnt[i] = (m_cnt[i] + 1) % dv;
                    if (tick && mode != 2'd3) begin
                        m_step[i] = 1'b1;
                        if (mode == 2'd2) begin
                            m_k[i]    = (m_k[i] + 1) % (n + 1);
                            m_wrap[i] = (m_k[i] == 0);
                        end else if (m_idle[i]) begin
                            m_idle[i] = 1'b0;
                            m_k[i]    = 0;
                        end else begin
                            per       = (mode == 2'd0) ? n : 2 * n - 2;
                            m_k[i]    = (m_k[i] + 1) % per;
                            m_wrap[i] = (m_k[i] == 0);
                        end
                    end
                end
                m_mq[i] = mode;
                m_dq[i] = dir;
            end
        end
    endtask

    function automatic logic [31:0] model_led(input int i);
        logic [31:0] v;
        int n;
        int pos;
        v = '0;
        n = (i == 0) ? N0 : N1;
        if ((m_mq[i] == 2'd0 || m_mq[i] == 2'd1) && !m_idle[i]) begin
            if (m_mq[i] == 2'd0) pos = m_k[i];
            else pos = (m_k[i] < n) ? m_k[i] : 2 * n - 2 - m_k[i];
            v[m_dq[i] ? n - 1 - pos : pos] = 1'b1;
        end else if (m_mq[i] == 2'd2) begin
            for (int b = 0; b < m_k[i]; b++) v[m_dq[i] ? n - 1 - b : b] = 1'b1;
        end
        return v;
    endfunction

    task automatic cycle(input logic r, input logic e, input logic [1:0] m, input logic d);
        rst  = r;
        en   = e;
        mode = m;
        dir  = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Run until dut0 steps, bounded; gap is the number of cycles taken.
    task automatic wait_step0(input logic [1:0] m, input logic d, output int gap, output bit got);
        gap = 0;
        got = 1'b0;
        while (!got && gap < 40) begin
            cycle(1'b0, 1'b1, m, d);
            gap++;
            got = step0;
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic        dir;
        int          dut;
        logic [31:0] led;
        logic        wrap;
        bit          first;
    } vec_t;

    vec_t vecs[$];

    initial begin : wdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int       gap;
        bit       got;
        int       nz;
        int       ns;
        logic     sel_step;
        logic     sel_wrap;
        logic [31:0] sel_led;
        logic [1:0]  rm;
        logic        rd;

        vecs.push_back('{2'd0, 1'b0, 0, 32'h01, 1'b0, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 0, 32'h02, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 1'b0, 0, 32'h04, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 1'b0, 0, 32'h08, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 1'b0, 0, 32'h01, 1'b1, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 0, 32'h01, 1'b0, 1'b1});
        vecs.push_back('{2'd1, 1'b0, 0, 32'h02, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 0, 32'h04, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 0, 32'h08, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 0, 32'h04, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 0, 32'h02, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 0, 32'h01, 1'b1, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 0, 32'h02, 1'b0, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 1, 32'h10, 1'b0, 1'b1});
        vecs.push_back('{2'd2, 1'b1, 1, 32'h18, 1'b0, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 1, 32'h1C, 1'b0, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 1, 32'h1E, 1'b0, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 1, 32'h1F, 1'b0, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 1, 32'h00, 1'b1, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 1, 32'h10, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 1'b1, 1, 32'h10, 1'b0, 1'b1});
        vecs.push_back('{2'd0, 1'b1, 1, 32'h08, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 1'b1, 1, 32'h04, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 1'b1, 1, 32'h02, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 1'b1, 1, 32'h01, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 1'b1, 1, 32'h10, 1'b1, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h10, 1'b0, 1'b1});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h08, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h04, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h02, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h01, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h02, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h04, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h08, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 1, 32'h10, 1'b1, 1'b0});

        rst = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b1, 2'd0, 1'b0);
        cycle(1'b1, 1'b1, 2'd0, 1'b0);
        check("reset_led0", 32'(led0), 32'h0);
        check("reset_step0", 32'(step0), 32'h0);
        check("reset_wrap0", 32'(wrap0), 32'h0);
        check("reset_led1", 32'(led1), 32'h0);
        check("reset_step1", 32'(step1), 32'h0);
        check("reset_wrap1", 32'(wrap1), 32'h0);

        foreach (vecs[j]) begin
            if (vecs[j].first) begin
                cycle(1'b1, 1'b1, vecs[j].mode, vecs[j].dir);
                cycle(1'b1, 1'b1, vecs[j].mode, vecs[j].dir);
            end
            gap = 0;
            got = 1'b0;
            while (!got && gap < 40) begin
                cycle(1'b0, 1'b1, vecs[j].mode, vecs[j].dir);
                gap++;
                sel_step = (vecs[j].dut == 0) ? step0 : step1;
                sel_wrap = (vecs[j].dut == 0) ? wrap0 : wrap1;
                got = sel_step;
                if (!got) check("tbl_wrap_without_step", 32'(sel_wrap), 32'h0);
            end
            sel_led  = (vecs[j].dut == 0) ? 32'(led0) : 32'(led1);
            sel_wrap = (vecs[j].dut == 0) ? wrap0 : wrap1;
            check("tbl_step_seen", 32'(got), 32'h1);
            check("tbl_led", sel_led, vecs[j].led);
            check("tbl_wrap", 32'(sel_wrap), 32'(vecs[j].wrap));
            if (!vecs[j].first) check("tbl_step_gap", 32'(gap), (vecs[j].dut == 0) ? 32'(D0) : 32'(D1));
        end

        // HOLD entry clears the pattern and suppresses steps; leaving restarts at S.
        cycle(1'b1, 1'b1, 2'd0, 1'b0);
        for (int s = 0; s < 3; s++) wait_step0(2'd0, 1'b0, gap, got);
        check("hold_pre_led", 32'(led0), 32'h4);
        cycle(1'b0, 1'b1, 2'd3, 1'b0);
        check("hold_entry_led", 32'(led0), 32'h0);
        check("hold_entry_step", 32'(step0), 32'h0);
        nz = 0;
        ns = 0;
        for (int c = 0; c < 20 * D0; c++) begin
            cycle(1'b0, 1'b1, 2'd3, 1'b0);
            if (led0 != '0) nz++;
            if (step0) ns++;
        end
        check("hold_led_nonzero_cycles", 32'(nz), 32'h0);
        check("hold_step_count", 32'(ns), 32'h0);
        cycle(1'b0, 1'b1, 2'd0, 1'b0);
        check("hold_exit_led", 32'(led0), 32'h0);
        wait_step0(2'd0, 1'b0, gap, got);
        check("hold_exit_step_seen", 32'(got), 32'h1);
        check("hold_exit_led_first", 32'(led0), 32'h1);
        check("hold_exit_gap", 32'(gap), 32'(D0));

        // Freeze mid-count: two counted cycles, ten frozen, then the remainder.
        cycle(1'b0, 1'b1, 2'd0, 1'b0);
        cycle(1'b0, 1'b1, 2'd0, 1'b0);
        nz = 0;
        ns = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b0, 2'd0, 1'b0);
            if (led0 != 4'h1) nz++;
            if (step0) ns++;
        end
        check("freeze_led_changes", 32'(nz), 32'h0);
        check("freeze_steps", 32'(ns), 32'h0);
        wait_step0(2'd0, 1'b0, gap, got);
        check("resume_step_seen", 32'(got), 32'h1);
        check("resume_gap", 32'(gap), 32'(D0 - 2));
        check("resume_led", 32'(led0), 32'h2);

        // Reset asserted exactly on the tick cycle.
        for (int c = 0; c < D0 - 1; c++) cycle(1'b0, 1'b1, 2'd0, 1'b0);
        check("pre_rst_no_step", 32'(step0), 32'h0);
        cycle(1'b1, 1'b1, 2'd0, 1'b0);
        check("rst_tick_led", 32'(led0), 32'h0);
        check("rst_tick_step", 32'(step0), 32'h0);
        check("rst_tick_wrap", 32'(wrap0), 32'h0);
        wait_step0(2'd0, 1'b0, gap, got);
        check("post_rst_step_seen", 32'(got), 32'h1);
        check("post_rst_led", 32'(led0), 32'h1);
        check("post_rst_wrap", 32'(wrap0), 32'h0);
        check("post_rst_gap", 32'(gap), 32'(D0));

        // Randomized run against the reference model, both instances every cycle.
        rm = 2'd0;
        rd = 1'b0;
        cycle(1'b1, 1'b1, rm, rd);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                rm = 2'($urandom_range(0, 3));
                rd = 1'($urandom_range(0, 1));
            end
            cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) != 0), rm, rd);
            check("rand_led0", 32'(led0), model_led(0));
            check("rand_step0", 32'(step0), 32'(m_step[0]));
            check("rand_wrap0", 32'(wrap0), 32'(m_wrap[0]));
            check("rand_led1", 32'(led1), model_led(1));
            check("rand_step1", 32'(step1), 32'(m_step[1]));
            check("rand_wrap1", 32'(wrap1), 32'(m_wrap[1]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Parametrised LED pattern sequencer for the board LED bank. It replaces the fixed 4-LED walking-one block.
- Single clock domain; the slow rate comes from a clock-enable tick, not a derived clock.
- Configurable LED count and step period.
- Four run-time modes: rotate, bounce, bar-fill, hold. Direction is selectable.
- Drives top-level LED pins directly; mode/dir/en come from switches or a CPU register.

Parameters:
N_LEDS, 4, number of LEDs driven; legal range 2..32.
DIV, 2500000, clk cycles per pattern step; legal range 2..2^32-1.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  run enable; 0 freezes the divider and the pattern
mode  in  2  0=ROTATE, 1=BOUNCE, 2=FILL, 3=HOLD
dir  in  1  0=towards MSB (from bit 0), 1=towards bit 0 (from MSB)
led  out  N_LEDS  LED drive, 1=on
step  out  1  one-cycle pulse on each pattern update
wrap  out  1  one-cycle pulse when the pattern returns to its start value

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. rst dominates every other input.
- Reset values: led=0, step=0, wrap=0, divider count=0, bounce flag=dir-of-travel up, mode_q=0, dir_q=0.
- Divider count width is $clog2(DIV).
  - If en=1: count increments each cycle; at DIV-1 it goes to 0 and an internal tick fires.
  - If en=0: count holds and no tick is generated.
- Change detect: mode_q and dir_q register mode and dir every cycle.
  - If (mode,dir) differs from (mode_q,dir_q): next cycle led=0, divider count=0, any same-cycle tick is discarded.
  - Change wins over tick.
- On tick, led updates and step pulses in the same cycle. step has 1-cycle latency from the tick, so led changes DIV cycles after the previous step.
- Start pattern (S), applied when led=0 or led is not legal for the mode:
  - ROTATE/BOUNCE: one-hot bit0 if dir=0, bit N-1 if dir=1.
  - FILL: led stays 0; the first tick lights the first bar.
- ROTATE: rotate one-hot by 1 toward MSB (dir=0) or LSB (dir=1), with wrap-around. wrap pulses when the result equals S.
- BOUNCE: one-hot moves, reversing at either end; end LEDs are lit once per turn. For N=4, dir=0 the sequence is 0001,0010,0100,1000,0100,0010,0001,0010… wrap pulses on each return to S.
- FILL: bar grows one LED per tick from bit0 (dir=0) or from MSB (dir=1). After all ones, the next tick gives 0, with N+1 states. wrap pulses on the all-ones to 0 transition.
- HOLD: ticks are ignored, led is frozen and step is not pulsed. Leaving HOLD is a mode change, so led is cleared.
- Mid-operation reset: led=0 on the cycle after rst is sampled high. The sequence restarts at S on the first tick after rst drops.

Optional Feature:
Macro: LED_SEQ_PWM_EN.
- Defined:
  - Adds input bright[7:0] and a free-running 8-bit pwm counter (reset 0).
  - Output becomes led = pattern & {N{pwm_cnt < bright}}.
  - bright=0 means dark; bright=255 means 255/256 duty.
  - step and wrap are unaffected.
- Undefined: no bright port, led = pattern.

Decomposition:
- Package led_seq_pkg holds:
  - led_mode_e enum: MODE_ROTATE, MODE_BOUNCE, MODE_FILL, MODE_HOLD.
  - PWM_W=8 constant.
- Sub-module led_tick_gen(DIV): divider plus en gating plus sync clear. Output is a one-cycle tick.

Test Plan:
- N=4, DIV=4, mode=0, dir=0, en=1 after reset → led 0001,0010,0100,1000,0001 at steps 1..5, 4 clk apart; wrap pulses at step 5 only.
- N=4, DIV=2, mode=1, dir=0 → 0001,0010,0100,1000,0100,0010,0001; wrap at the 7th step.
- N=5, DIV=3, mode=2, dir=1 → 10000,11000,11100,11110,11111,00000; wrap at the 6th step.
- In ROTATE at 0100, set mode=3 for 20 ticks → led holds 0100 (cleared first, since HOLD entry is a change: expect led=0 and no step). Then mode=0 → led 0001 on the first tick.
- en=0 for 10 cycles mid-count → divider and led frozen; resume continues the count with no lost or extra step. Assert rst on a tick cycle → led=0 next cycle, and no step.
- LED_SEQ_PWM_EN, bright=64, led pattern 1111 → each LED on for exactly 64 of every 256 cycles.
